// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin arbiter between two pixel producers feeding the framebuffer write port
// through a small FIFO, with off-screen dropping and a flush/done handshake.
module fb_write_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int COLOR_W   = 4,
  parameter int FB_PIXELS = 307200,
  parameter int DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_phase,
  input  logic               flush,
  input  logic               a_req,
  input  logic               b_req,
  input  logic [ADDR_W-1:0]  a_addr,
  input  logic [ADDR_W-1:0]  b_addr,
  input  logic [COLOR_W-1:0] a_color,
  input  logic [COLOR_W-1:0] b_color,
  output logic               a_gnt,
  output logic               b_gnt,
  output logic               fb_en_w,
  output logic [ADDR_W-1:0]  fb_w_addr,
  output logic [COLOR_W-1:0] fb_color,
  output logic               fifo_empty,
  output logic               flush_done,
  output logic [15:0]        drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];
  localparam logic [ADDR_W:0] LIMIT = FB_PIXELS[ADDR_W:0];
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
  state_t r_state, w_next;
  logic [PW:0] r_count;
  logic [PW-1:0] r_wptr, r_rptr;
  logic r_last_b;
  logic [15:0] r_drop_cnt;
  logic [ADDR_W+COLOR_W-1:0] r_mem [DEPTH];
  logic w_elig, w_xfer, w_push, w_drop, w_pop;
  logic [ADDR_W-1:0] w_addr;
  logic [COLOR_W-1:0] w_color;
  always_comb begin
    w_elig  = r_state == RUN && r_count < FULL;
    a_gnt   = w_elig && a_req && (!b_req || r_last_b);
    b_gnt   = w_elig && b_req && (!a_req || !r_last_b);
    w_xfer  = a_gnt || b_gnt;
    w_addr  = a_gnt ? a_addr : b_addr;
    w_color = a_gnt ? a_color : b_color;
    w_push  = w_xfer && {1'b0, w_addr} < LIMIT;
    w_drop  = w_xfer && !w_push;
    w_pop   = wr_phase && r_count != '0;
    w_next  = (r_state == RUN && flush) ? FLUSH :
              (r_state == FLUSH && r_count == '0 && !fb_en_w) ? DONE :
              (r_state == DONE) ? RUN : r_state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RUN;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_last_b   <= 1'b1;
      r_drop_cnt <= '0;
      fb_en_w    <= 1'b0;
      fb_w_addr  <= '0;
      fb_color   <= '0;
    end else begin
      r_state <= w_next;
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (a_gnt) r_last_b <= 1'b0;
      else if (b_gnt) r_last_b <= 1'b1;
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      fb_en_w <= w_pop;
      if (w_pop) {fb_w_addr, fb_color} <= r_mem[r_rptr];
    end
  end
  // storage needs no reset: reset clears the pointers, so stale entries are never read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_addr, w_color};
  end
  assign fifo_empty = r_count == '0 && !fb_en_w;
  assign flush_done = r_state == DONE;
  assign drop_cnt   = r_drop_cnt;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed test of fb_write_arbiter with hand-computed expectations.
module tb_fb_write_arbiter;
  logic clk = 1'b0;
  logic rst, wr_phase, flush, a_req, b_req;
  logic [18:0] a_addr, b_addr;
  logic [3:0] a_color, b_color;
  logic a_gnt, b_gnt, fb_en_w, fifo_empty, flush_done;
  logic [18:0] fb_w_addr;
  logic [3:0] fb_color;
  logic [15:0] drop_cnt;
  int total = 0;
  int bad = 0;
  fb_write_arbiter dut (
    .clk(clk), .rst(rst), .wr_phase(wr_phase), .flush(flush),
    .a_req(a_req), .b_req(b_req), .a_addr(a_addr), .b_addr(b_addr),
    .a_color(a_color), .b_color(b_color), .a_gnt(a_gnt), .b_gnt(b_gnt),
    .fb_en_w(fb_en_w), .fb_w_addr(fb_w_addr), .fb_color(fb_color),
    .fifo_empty(fifo_empty), .flush_done(flush_done), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic do_reset();
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    rst = 1'b0; wr_phase = 1'b0; flush = 1'b0; a_req = 1'b0; b_req = 1'b0;
    a_addr = '0; b_addr = '0; a_color = '0; b_color = '0;
    #1;
    chk("rst_en", fb_en_w, 0);
    chk("rst_addr", fb_w_addr, 0);
    chk("rst_color", fb_color, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_done", flush_done, 0);
    chk("rst_drop", drop_cnt, 0);
    cyc();
    rst = 1'b1;
    // single pixel latency
    cyc(); wr_phase = 1'b1; a_req = 1'b1; a_addr = 19'd100; a_color = 4'h3; #1;
    chk("t1_gnt", a_gnt, 1);
    cyc(); a_req = 1'b0; #1;
    chk("t1_en_n1", fb_en_w, 0);
    cyc(); #1;
    chk("t1_en_n2", fb_en_w, 1);
    chk("t1_addr", fb_w_addr, 100);
    chk("t1_color", fb_color, 3);
    cyc(); #1;
    chk("t1_en_n3", fb_en_w, 0);
    chk("t1_empty", fifo_empty, 1);
    // round-robin from reset: A wins first tie
    do_reset();
    wr_phase = 1'b1;
    a_color = 4'h5; b_color = 4'hA;
    for (int i = 0; i < 9; i++) begin
      cyc();
      a_req = i < 6; b_req = i < 6;
      a_addr = 19'(1000 + i); b_addr = 19'(2000 + i);
      #1;
      if (i < 6) begin
        chk($sformatf("rr_agnt%0d", i), a_gnt, (i % 2) == 0);
        chk($sformatf("rr_bgnt%0d", i), b_gnt, (i % 2) == 1);
      end
      if (i >= 2 && i < 8) begin
        chk($sformatf("rr_en%0d", i), fb_en_w, 1);
        chk($sformatf("rr_addr%0d", i), fb_w_addr, ((i - 2) % 2 == 0) ? 1000 + i - 2 : 2000 + i - 2);
        chk($sformatf("rr_col%0d", i), fb_color, ((i - 2) % 2 == 0) ? 32'h5 : 32'hA);
      end else chk($sformatf("rr_en%0d", i), fb_en_w, 0);
    end
    // full / stall
    wr_phase = 1'b0; a_color = 4'h1;
    for (int i = 0; i < 5; i++) begin
      cyc(); a_req = 1'b1; a_addr = 19'(50 + i); #1;
      chk($sformatf("st_gnt%0d", i), a_gnt, i < 4);
    end
    chk("st_empty", fifo_empty, 0);
    cyc(); wr_phase = 1'b1; #1;
    chk("st_nopush", a_gnt, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); a_req = 1'b0; #1;
      chk($sformatf("st_en%0d", i), fb_en_w, 1);
      chk($sformatf("st_addr%0d", i), fb_w_addr, 50 + i);
    end
    cyc(); a_req = 1'b1; a_addr = 19'd60; #1;
    chk("st_en_end", fb_en_w, 0);
    chk("st_resume", a_gnt, 1);
    cyc(); a_req = 1'b0;
    cyc(); #1;
    chk("st_last_addr", fb_w_addr, 60);
    cyc();
    // off-screen drop and saturation
    cyc(); b_req = 1'b1; b_addr = 19'd307200; b_color = 4'h7; #1;
    chk("dr_gnt0", b_gnt, 1);
    chk("dr_cnt0", drop_cnt, 0);
    cyc(); b_addr = 19'd307199; b_color = 4'h8; #1;
    chk("dr_gnt1", b_gnt, 1);
    chk("dr_cnt1", drop_cnt, 1);
    cyc(); b_req = 1'b0; #1;
    chk("dr_noen", fb_en_w, 0);
    cyc(); #1;
    chk("dr_en", fb_en_w, 1);
    chk("dr_addr", fb_w_addr, 307199);
    chk("dr_color", fb_color, 8);
    chk("dr_cnt2", drop_cnt, 1);
    cyc(); force dut.r_drop_cnt = 16'hFFFF;
    cyc(); release dut.r_drop_cnt;
    b_req = 1'b1; b_addr = 19'd400000; #1;
    chk("dr_gnt2", b_gnt, 1);
    cyc(); b_req = 1'b0; #1;
    chk("dr_sat", drop_cnt, 16'hFFFF);
    cyc(); #1;
    chk("dr_sat_noen", fb_en_w, 0);
    // flush drain
    wr_phase = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); a_req = 1'b1; a_addr = 19'(70 + i); #1;
      chk($sformatf("fl_gnt%0d", i), a_gnt, 1);
    end
    cyc(); a_req = 1'b0; flush = 1'b1; wr_phase = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); flush = 1'b0; a_req = 1'b1; a_addr = 19'd99; #1;
      chk($sformatf("fl_nognt%0d", i), a_gnt, 0);
      chk($sformatf("fl_en%0d", i), fb_en_w, 1);
      chk($sformatf("fl_addr%0d", i), fb_w_addr, 70 + i);
      chk($sformatf("fl_nodone%0d", i), flush_done, 0);
    end
    cyc(); #1;
    chk("fl_en_off", fb_en_w, 0);
    chk("fl_done_wait", flush_done, 0);
    chk("fl_nognt3", a_gnt, 0);
    cyc(); #1;
    chk("fl_done", flush_done, 1);
    chk("fl_nognt4", a_gnt, 0);
    cyc(); #1;
    chk("fl_done_end", flush_done, 0);
    chk("fl_resume", a_gnt, 1);
    cyc(); a_req = 1'b0;
    cyc(); cyc(); cyc();
    // async reset mid-drain
    wr_phase = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(); a_req = 1'b1; a_addr = 19'(80 + i); a_color = 4'h9; #1;
      chk($sformatf("ar_gnt%0d", i), a_gnt, 1);
    end
    cyc(); a_req = 1'b0; flush = 1'b1;
    cyc(); flush = 1'b0; a_req = 1'b1; #1;
    chk("ar_flush_nognt", a_gnt, 0);
    chk("ar_pre_empty", fifo_empty, 0);
    chk("ar_pre_drop", drop_cnt, 16'hFFFF);
    #1 rst = 1'b0;
    #1;
    chk("ar_empty", fifo_empty, 1);
    chk("ar_en", fb_en_w, 0);
    chk("ar_addr", fb_w_addr, 0);
    chk("ar_color", fb_color, 0);
    chk("ar_drop", drop_cnt, 0);
    chk("ar_gnt", a_gnt, 1);
    a_req = 1'b0;
    cyc(); rst = 1'b1; wr_phase = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk($sformatf("ar_post_en%0d", i), fb_en_w, 0);
      chk($sformatf("ar_post_done%0d", i), flush_done, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
